// File: rtl/tdm_pkg.sv
// Shared types for the TDM receive path.
// Slot index, framer state and slot wrap helper.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

  function automatic slot_t slot_next(slot_t s);
    return (s == LAST_SLOT) ? '0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter for the TDM demux.
// clear wins over load_one, which wins over advance.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       advance,
  input  logic       load_one,
  input  logic       clear,
  output logic [1:0] sel
);

  // Slot index expected on the next valid beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel <= '0;
    end else if (clear) begin
      sel <= '0;
    end else if (load_one) begin
      sel <= 2'd1;
    end else if (advance) begin
      sel <= slot_next(sel);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// TDM 1-to-4 demux: framer, shadow and output registers.
// Optional 8-bit error counter under TDM_DEMUX_ERRCNT_EN.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync_in,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic [1:0]       sel,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  state_t state;

  logic [WIDTH-1:0] sh0;
  logic [WIDTH-1:0] sh1;
  logic [WIDTH-1:0] sh2;

  logic take0;
  logic take1;
  logic take2;
  logic take3;
  logic drop;
  logic err_evt;

  // Decode the current beat into exactly one action.
  always_comb begin
    take0   = 1'b0;
    take1   = 1'b0;
    take2   = 1'b0;
    take3   = 1'b0;
    drop    = 1'b0;
    err_evt = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          take0 = sync_in;
        end
        LOCKED: begin
          unique case (1'b1)
            sync_in: begin
              take0   = 1'b1;
              err_evt = (sel != 2'd0);
            end
            (!sync_in && sel == 2'd0): begin
              drop    = 1'b1;
              err_evt = 1'b1;
            end
            (!sync_in && sel == 2'd1): take1 = 1'b1;
            (!sync_in && sel == 2'd2): take2 = 1'b1;
            (!sync_in && sel == 2'd3): take3 = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  tdm_slot_counter u_slot (
    .clock    (clock),
    .reset_n  (reset_n),
    .advance  (take1 | take2 | take3),
    .load_one (take0),
    .clear    (drop),
    .sel      (sel)
  );

  // Framer state, shadows and atomic output update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      dout0       <= '0;
      dout1       <= '0;
      dout2       <= '0;
      dout3       <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= take3;
      sync_err    <= err_evt;
      if (take0) begin
        sh0   <= din;
        state <= LOCKED;
      end
      if (drop) begin
        state <= HUNT;
      end
      if (take1) begin
        sh1 <= din;
      end
      if (take2) begin
        sh2 <= din;
      end
      if (take3) begin
        dout0 <= sh0;
        dout1 <= sh1;
        dout2 <= sh2;
        dout3 <= din;
      end
    end
  end

  assign locked = (state == LOCKED);

`ifdef TDM_DEMUX_ERRCNT_EN
  localparam logic [7:0] ERR_MAX = 8'hFF;

  // Saturating count of framing violations.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (err_evt && err_count != ERR_MAX) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 (WIDTH=1).
// Frames and sync errors are queued by stimulus, popped by a monitor.
module tb_tdm_demux4;

  logic       clock;
  logic       reset_n;
  logic [0:0] din;
  logic       din_valid;
  logic       sync_in;
  logic [0:0] dout0;
  logic [0:0] dout1;
  logic [0:0] dout2;
  logic [0:0] dout3;
  logic [1:0] sel;
  logic       frame_valid;
  logic       sync_err;
  logic       locked;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [3:0] exp_q[$];
  int         pend_err = 0;
  logic       prev_fv = 1'b0;
  logic       prev_se = 1'b0;

  tdm_demux4 #(.WIDTH(1)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync_in     (sync_in),
    .dout0       (dout0),
    .dout1       (dout1),
    .dout2       (dout2),
    .dout3       (dout3),
    .sel         (sel),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic beat(input logic d, input logic s);
    din       = d;
    din_valid = 1'b1;
    sync_in   = s;
    @(posedge clock);
    #1;
    din_valid = 1'b0;
    sync_in   = 1'b0;
    din       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic int douts();
    return int'({dout0, dout1, dout2, dout3});
  endfunction

  // Monitor: pop expected frames / errors when the DUT presents them.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_fv <= 1'b0;
      prev_se <= 1'b0;
    end else begin
      if (frame_valid) begin
        checks++;
        if (prev_fv) begin
          failures++;
          $display("FAIL fv_width: got 2-cycle pulse expected 1");
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL frame_unexp: got frame %b expected none",
                   {dout0, dout1, dout2, dout3});
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          checks++;
          if ({dout0, dout1, dout2, dout3} != e) begin
            failures++;
            $display("FAIL frame_data: got %b expected %b",
                     {dout0, dout1, dout2, dout3}, e);
          end
        end
      end
      if (sync_err) begin
        checks++;
        if (prev_se || pend_err == 0) begin
          failures++;
          $display("FAIL err_unexp: got sync_err expected none");
        end else begin
          pend_err--;
        end
      end
      prev_fv <= frame_valid;
      prev_se <= sync_err;
    end
  end

  initial begin
    reset_n   = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    sync_in   = 1'b0;
    #3;
    chk("rst_dout", douts(), 0);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_err", int'(sync_err), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_sel", int'(sel), 0);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("rst_errcnt", int'(err_count), 0);
`endif
    idle(2);
    reset_n = 1'b1;
    idle(1);

    // back-to-back frame 1,0,1,1
    exp_q.push_back(4'b1011);
    beat(1'b1, 1'b1);
    chk("b2b_locked0", int'(locked), 1);
    chk("b2b_sel0", int'(sel), 1);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    chk("b2b_nofv", int'(frame_valid), 0);
    beat(1'b1, 1'b0);
    chk("b2b_fv", int'(frame_valid), 1);
    chk("b2b_dout", douts(), 4'b1011);
    chk("b2b_locked", int'(locked), 1);
    chk("b2b_sel", int'(sel), 0);
    idle(1);
    chk("b2b_fv_off", int'(frame_valid), 0);

    // gapped frame 0,1,1,0 with 0..3 idle cycles
    exp_q.push_back(4'b0110);
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    idle(1);
    beat(1'b1, 1'b0);
    idle(2);
    chk("gap_nofv", int'(frame_valid), 0);
    chk("gap_hold", douts(), 4'b1011);
    beat(1'b0, 1'b0);
    chk("gap_fv", int'(frame_valid), 1);
    chk("gap_dout", douts(), 4'b0110);
    idle(3);

    // sync on slot 2 restarts the frame
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    pend_err++;
    beat(1'b1, 1'b1);
    chk("s2_err", int'(sync_err), 1);
    chk("s2_nofv", int'(frame_valid), 0);
    chk("s2_dout", douts(), 4'b0110);
    chk("s2_sel", int'(sel), 1);
    chk("s2_locked", int'(locked), 1);
    exp_q.push_back(4'b1010);
    beat(1'b0, 1'b0);
    chk("s2_err_off", int'(sync_err), 0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    chk("s2_fv", int'(frame_valid), 1);
    chk("s2_dout2", douts(), 4'b1010);

    // slot 0 without sync drops lock
    pend_err++;
    beat(1'b1, 1'b0);
    chk("s0_err", int'(sync_err), 1);
    chk("s0_locked", int'(locked), 0);
    chk("s0_sel", int'(sel), 0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    chk("s0_nofv", int'(frame_valid), 0);
    chk("s0_hunt", int'(locked), 0);
    chk("s0_dout", douts(), 4'b1010);

    // reset mid-frame
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_dout", douts(), 0);
    chk("mrst_locked", int'(locked), 0);
    chk("mrst_sel", int'(sel), 0);
    idle(2);
    reset_n = 1'b1;
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    chk("mrst_hunt", int'(locked), 0);
    exp_q.push_back(4'b1110);
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    chk("mrst_nofv", int'(frame_valid), 0);
    beat(1'b0, 1'b0);
    chk("mrst_fv", int'(frame_valid), 1);
    chk("mrst_dout2", douts(), 4'b1110);

`ifdef TDM_DEMUX_ERRCNT_EN
    // 300 forced errors: each extra sync beat errors
    beat(1'b1, 1'b1);
    pend_err += 300;
    for (int i = 0; i < 300; i++) beat(1'b0, 1'b1);
    idle(2);
    chk("cnt_sat", int'(err_count), 255);
    reset_n = 1'b0;
    #1;
    chk("cnt_rst", int'(err_count), 0);
    idle(1);
    reset_n = 1'b1;
`endif

    idle(3);
    chk("frames_left", exp_q.size(), 0);
    chk("errs_left", pend_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
